variable_latency_bank_responder: RTL and testbench
==================================================

Name: variable_latency_bank_responder

Overview:
- Target-side endpoint for the variable-latency TCDM interconnect; one instance sits behind each target port.
- Accepts valid/ready requests, drives a fixed-latency SRAM bank, and returns read data tagged with the initiator address.
- A response FIFO plus an outstanding-request counter guarantee that no response is ever dropped under downstream backpressure.

Parameters:
- NumIn, 32, number of initiators; tag width is $clog2(NumIn).
- AddrMemWidth, 12, bank word-address width.
- DataWidth, 32, data word width.
- BeWidth, DataWidth/8, byte-enable width.
- MemLatency, 1, SRAM read latency in cycles (>=1).
- RespFifoDepth, MemLatency+1, response FIFO entries (>=MemLatency+1 required for full throughput; >=1 legal).
- WriteResp, 1'b0, 1: writes also return a response (rdata=0); 0: writes are silent.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_ini_addr_i  in  $clog2(NumIn)  initiator tag.
- req_tgt_addr_i  in  AddrMemWidth  bank word address.
- req_wen_i  in  1  write enable.
- req_wdata_i  in  DataWidth  write data.
- req_be_i  in  BeWidth  byte enable.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  response ready.
- resp_ini_addr_o  out  $clog2(NumIn)  response tag.
- resp_rdata_o  out  DataWidth  read data.
- mem_req_o  out  1  SRAM access strobe.
- mem_addr_o  out  AddrMemWidth  SRAM address.
- mem_wen_o  out  1  SRAM write enable.
- mem_wdata_o  out  DataWidth  SRAM write data.
- mem_be_o  out  BeWidth  SRAM byte enable.
- mem_rdata_i  in  DataWidth  SRAM read data, valid MemLatency cycles after the strobe.

Behaviour:
- Clock is clk_i. Reset is rst_i: asynchronous, active-high, single clock domain.
- Reset (any time, including mid-transfer):
  - req_ready_o=0 while rst_i is high.
  - resp_valid_o=0, mem_req_o=0.
  - Pipeline, FIFO and counter are cleared; in-flight requests are discarded.
- Accept:
  - Handshake = req_valid_i & req_ready_o. mem_req_o = handshake, combinational, same cycle.
  - mem_addr/wen/wdata/be are a direct pass-through of the req_* fields.
  - req_valid_i must not depend on req_ready_o. A held request must keep stable payload until accepted.
- Credit:
  - Register cnt, width $clog2(RespFifoDepth+1), counts response-producing requests that are accepted but not yet popped.
  - A request produces a response if it is a read, or a write with WriteResp=1.
  - req_ready_o = (cnt < RespFifoDepth). It depends only on registered state; there is no combinational path from resp_ready_i.
  - Next cnt = cnt + accept_resp - pop. Simultaneous accept and pop leaves cnt unchanged.
  - Silent writes are accepted whenever cnt < RespFifoDepth and never change cnt.
- Tag pipeline:
  - MemLatency-deep shift register of {vld, ini_addr, is_write}. Stage 0 is loaded on handshake for response-producing requests.
  - At the last stage, vld pushes {ini_addr, is_write ? '0 : mem_rdata_i} into the FIFO.
- FIFO:
  - Fall-through. resp_valid_o = FIFO non-empty or push this cycle.
  - Pop = resp_valid_o & resp_ready_i.
  - Minimum latency: accept at cycle t gives resp_valid_o at t+MemLatency.
  - Push while full cannot occur because the credit invariant prevents it; an assertion checks this.
  - Order is strictly in-order.
- Throughput:
  - One request per cycle sustained when RespFifoDepth >= MemLatency+1 and resp_ready_i=1.
  - Smaller depth throttles throughput; it never causes loss.
- Once resp_valid_o is asserted, it and its payload hold until popped.
- Assertions:
  - MemLatency >= 1.
  - RespFifoDepth >= 1.
  - No FIFO overflow.
  - cnt <= RespFifoDepth.

Decomposition:
- Add to tcdm_interconnect_pkg a packed struct resp_entry_t {ini_addr, rdata}. Width is parameterised through the module, so the struct stays local if the package cannot hold parameterised types.
- One sub-module: variable_latency_resp_fifo, a fall-through FIFO (asynchronous active-high reset, parameters Depth and type T, with push/pop/full/empty).
- The tag shift register and credit counter stay in the top module.

Test Plan:
- Reset, then single read with MemLatency=2, tag 5, addr 0x010, SRAM returns 0xDEADBEEF:
  - mem_req_o pulses in the accept cycle.
  - resp_valid_o rises exactly 2 cycles later with resp_ini_addr_o=5, resp_rdata_o=0xDEADBEEF.
  - cnt returns to 0.
- Back-to-back reads for 16 cycles, resp_ready_i=1, MemLatency=1, depth=2:
  - req_ready_o stays 1 every cycle.
  - 16 responses arrive in order with the correct tags.
- Backpressure, resp_ready_i=0, depth=2, MemLatency=1, continuous reads:
  - Exactly 2 accepted, then req_ready_o=0.
  - After resp_ready_i=1, both responses drain in order and accepts resume 1 cycle after the first pop.
- Writes:
  - WriteResp=0: a write (be=4'b0011) drives mem_wen_o=1, mem_be_o=0011, and no response ever appears.
  - WriteResp=1: a response with rdata=0 and the correct tag appears after MemLatency.
- Simultaneous accept and pop at cnt=depth-1: cnt is unchanged and req_ready_o stays 1.
- rst_i asserted with 2 requests in flight and 1 in the FIFO:
  - Outputs drop immediately (asynchronous).
  - After release, no stale response appears and req_ready_o=1.

Source files
------------

// File: rtl/tcdm_interconnect_pkg.sv
// Shared definitions for the variable-latency TCDM interconnect target side.
// Parameterised payload types live next to their users; this holds defaults and helpers.
package tcdm_interconnect_pkg;

  localparam int unsigned DefaultNumIn        = 32;
  localparam int unsigned DefaultAddrMemWidth = 12;
  localparam int unsigned DefaultDataWidth    = 32;
  localparam int unsigned DefaultMemLatency   = 1;

  // Index width that stays legal for single-entry structures.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A read always answers; a write answers only when write responses are enabled.
  function automatic logic produces_resp(input logic wen, input logic write_resp);
    return !wen || write_resp;
  endfunction

endpackage

// File: rtl/variable_latency_resp_fifo.sv
// Fall-through response FIFO: a push into an empty FIFO is visible on rdata in the same cycle.
// Asynchronous active-high reset clears pointers and occupancy only.
module variable_latency_resp_fifo
  import tcdm_interconnect_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter type         T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int unsigned PtrW = idx_width(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  T                mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] count;
  logic            bypass;
  logic            do_write;
  logic            do_read;

  function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CntW'(Depth));
  // An entry pushed and popped in the same cycle while empty never touches storage.
  assign bypass   = empty & push & pop;
  assign do_write = push & ~bypass;
  assign do_read  = pop & ~empty;
  assign rdata    = empty ? wdata : mem[rd_ptr];

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= wrap_inc(wr_ptr);
      if (do_read)  rd_ptr <= wrap_inc(rd_ptr);
      count <= count + CntW'(do_write) - CntW'(do_read);
    end
  end

  // NOTE: storage has no reset; a slot is only read after being written, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/variable_latency_bank_responder.sv
// Target-side TCDM endpoint: accepts requests, drives a fixed-latency SRAM bank and returns
// tagged responses; a credit counter sized to the response FIFO makes response loss impossible.
module variable_latency_bank_responder
  import tcdm_interconnect_pkg::*;
#(
  parameter int unsigned NumIn         = DefaultNumIn,
  parameter int unsigned AddrMemWidth  = DefaultAddrMemWidth,
  parameter int unsigned DataWidth     = DefaultDataWidth,
  parameter int unsigned BeWidth       = DataWidth / 8,
  parameter int unsigned MemLatency    = DefaultMemLatency,
  parameter int unsigned RespFifoDepth = MemLatency + 1,
  parameter bit          WriteResp     = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [$clog2(NumIn)-1:0]   req_ini_addr_i,
  input  logic [AddrMemWidth-1:0]    req_tgt_addr_i,
  input  logic                       req_wen_i,
  input  logic [DataWidth-1:0]       req_wdata_i,
  input  logic [BeWidth-1:0]         req_be_i,
  output logic                       resp_valid_o,
  input  logic                       resp_ready_i,
  output logic [$clog2(NumIn)-1:0]   resp_ini_addr_o,
  output logic [DataWidth-1:0]       resp_rdata_o,
  output logic                       mem_req_o,
  output logic [AddrMemWidth-1:0]    mem_addr_o,
  output logic                       mem_wen_o,
  output logic [DataWidth-1:0]       mem_wdata_o,
  output logic [BeWidth-1:0]         mem_be_o,
  input  logic [DataWidth-1:0]       mem_rdata_i
);

  localparam int unsigned IniW = $clog2(NumIn);
  localparam int unsigned CntW = $clog2(RespFifoDepth + 1);

  if (MemLatency < 1) begin : g_bad_latency
    $error("MemLatency must be at least 1");
  end
  if (RespFifoDepth < 1) begin : g_bad_depth
    $error("RespFifoDepth must be at least 1");
  end

  typedef struct packed {
    logic [IniW-1:0]      ini_addr;
    logic [DataWidth-1:0] rdata;
  } resp_entry_t;

  logic [CntW-1:0]       cnt;
  logic                  handshake;
  logic                  accept_resp;
  logic                  pop;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;
  resp_entry_t           push_entry;
  resp_entry_t           head;
  logic [MemLatency-1:0] pipe_vld;
  logic [MemLatency-1:0] pipe_wr;
  logic [IniW-1:0]       pipe_ini [MemLatency];

  // Credit covers both in-flight SRAM reads and queued responses, so ready never
  // needs to look at resp_ready_i.
  assign req_ready_o = !rst_i && (cnt < CntW'(RespFifoDepth));
  assign handshake   = req_valid_i & req_ready_o;
  assign accept_resp = handshake & produces_resp(req_wen_i, WriteResp);

  assign mem_req_o   = handshake;
  assign mem_addr_o  = req_tgt_addr_i;
  assign mem_wen_o   = req_wen_i;
  assign mem_wdata_o = req_wdata_i;
  assign mem_be_o    = req_be_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld <= '0;
      cnt      <= '0;
    end else begin
      pipe_vld[0] <= accept_resp;
      for (int i = 1; i < MemLatency; i++) pipe_vld[i] <= pipe_vld[i-1];
      cnt <= cnt + CntW'(accept_resp) - CntW'(pop);
    end
  end

  // Tag payload travels alongside the valid bits; it is only meaningful where vld is set.
  always_ff @(posedge clk_i) begin
    if (accept_resp) begin
      pipe_ini[0] <= req_ini_addr_i;
      pipe_wr[0]  <= req_wen_i;
    end
    for (int i = 1; i < MemLatency; i++) begin
      pipe_ini[i] <= pipe_ini[i-1];
      pipe_wr[i]  <= pipe_wr[i-1];
    end
  end

  assign push = pipe_vld[MemLatency-1];

  always_comb begin
    // NOTE: assigning a full default first keeps this block free of inferred latches.
    push_entry          = '0;
    push_entry.ini_addr = pipe_ini[MemLatency-1];
    if (!pipe_wr[MemLatency-1]) push_entry.rdata = mem_rdata_i;
  end

  variable_latency_resp_fifo #(
    .Depth (RespFifoDepth),
    .T     (resp_entry_t)
  ) u_resp_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign resp_valid_o    = !fifo_empty || push;
  assign pop             = resp_valid_o & resp_ready_i;
  assign resp_ini_addr_o = head.ini_addr;
  assign resp_rdata_o    = head.rdata;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && fifo_full));
  a_cnt_bound:   assert property (@(posedge clk_i) disable iff (rst_i) cnt <= CntW'(RespFifoDepth));

endmodule

// File: tb/tb_variable_latency_bank_responder.sv
// Directed bench with a response scoreboard for two responder configurations:
// a = MemLatency 2 / depth 3 / write responses on, b = MemLatency 1 / depth 2 / silent writes.
module tb_variable_latency_bank_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_wen, a_resp_valid, a_resp_ready;
  logic        a_mem_req, a_mem_wen;
  logic [4:0]  a_req_ini, a_resp_ini;
  logic [11:0] a_req_addr, a_mem_addr;
  logic [31:0] a_req_wdata, a_resp_rdata, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_req_be, a_mem_be;

  logic        b_req_valid, b_req_ready, b_req_wen, b_resp_valid, b_resp_ready;
  logic        b_mem_req, b_mem_wen;
  logic [4:0]  b_req_ini, b_resp_ini;
  logic [11:0] b_req_addr, b_mem_addr;
  logic [31:0] b_req_wdata, b_resp_rdata, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_req_be, b_mem_be;

  variable_latency_bank_responder #(
    .NumIn(32), .AddrMemWidth(12), .DataWidth(32), .MemLatency(2),
    .RespFifoDepth(3), .WriteResp(1'b1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_ini_addr_i(a_req_ini),
    .req_tgt_addr_i(a_req_addr), .req_wen_i(a_req_wen), .req_wdata_i(a_req_wdata),
    .req_be_i(a_req_be), .resp_valid_o(a_resp_valid), .resp_ready_i(a_resp_ready),
    .resp_ini_addr_o(a_resp_ini), .resp_rdata_o(a_resp_rdata), .mem_req_o(a_mem_req),
    .mem_addr_o(a_mem_addr), .mem_wen_o(a_mem_wen), .mem_wdata_o(a_mem_wdata),
    .mem_be_o(a_mem_be), .mem_rdata_i(a_mem_rdata)
  );

  variable_latency_bank_responder #(
    .NumIn(32), .AddrMemWidth(12), .DataWidth(32), .MemLatency(1),
    .RespFifoDepth(2), .WriteResp(1'b0)
  ) dut_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_ini_addr_i(b_req_ini),
    .req_tgt_addr_i(b_req_addr), .req_wen_i(b_req_wen), .req_wdata_i(b_req_wdata),
    .req_be_i(b_req_be), .resp_valid_o(b_resp_valid), .resp_ready_i(b_resp_ready),
    .resp_ini_addr_o(b_resp_ini), .resp_rdata_o(b_resp_rdata), .mem_req_o(b_mem_req),
    .mem_addr_o(b_mem_addr), .mem_wen_o(b_mem_wen), .mem_wdata_o(b_mem_wdata),
    .mem_be_o(b_mem_be), .mem_rdata_i(b_mem_rdata)
  );

  // SRAM model: read data is driven only in the cycle it is due, garbage otherwise.
  function automatic logic [31:0] sram_val(input logic [11:0] addr);
    return (addr == 12'h010) ? 32'hDEADBEEF : {8'hC3, 12'h000, addr};
  endfunction

  logic        a_rv0 = 1'b0, a_rv1 = 1'b0, b_rv0 = 1'b0;
  logic [11:0] a_ra0 = '0, a_ra1 = '0, b_ra0 = '0;
  always @(posedge clk) begin
    a_rv0 <= a_mem_req & ~a_mem_wen;
    a_ra0 <= a_mem_addr;
    a_rv1 <= a_rv0;
    a_ra1 <= a_ra0;
    b_rv0 <= b_mem_req & ~b_mem_wen;
    b_ra0 <= b_mem_addr;
  end
  assign a_mem_rdata = a_rv1 ? sram_val(a_ra1) : 32'hBAD0BAD0;
  assign b_mem_rdata = b_rv0 ? sram_val(b_ra0) : 32'hBAD0BAD0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard entries are {tag, rdata}.
  logic [36:0] q_a[$];
  logic [36:0] q_b[$];

  logic        a_stall = 1'b0, b_stall = 1'b0;
  logic [36:0] a_prev, b_prev, exp_e;
  always @(negedge clk) begin
    if (rst) begin
      a_stall = 1'b0;
      b_stall = 1'b0;
    end else begin
      if (a_stall) begin
        check("a_hold_valid", a_resp_valid, 1);
        check("a_hold_payload", {a_resp_ini, a_resp_rdata}, a_prev);
      end
      if (a_resp_valid && a_resp_ready) begin
        if (q_a.size() == 0) check("a_unexpected_resp", a_resp_valid, 0);
        else begin
          exp_e = q_a.pop_front();
          check("a_resp", {a_resp_ini, a_resp_rdata}, exp_e);
        end
      end
      a_stall = a_resp_valid && !a_resp_ready;
      a_prev  = {a_resp_ini, a_resp_rdata};

      if (b_stall) begin
        check("b_hold_valid", b_resp_valid, 1);
        check("b_hold_payload", {b_resp_ini, b_resp_rdata}, b_prev);
      end
      if (b_resp_valid && b_resp_ready) begin
        if (q_b.size() == 0) check("b_unexpected_resp", b_resp_valid, 0);
        else begin
          exp_e = q_b.pop_front();
          check("b_resp", {b_resp_ini, b_resp_rdata}, exp_e);
        end
      end
      b_stall = b_resp_valid && !b_resp_ready;
      b_prev  = {b_resp_ini, b_resp_rdata};
    end
  end

  // Presents one request, waits (bounded) for acceptance, checks the SRAM strobe and
  // records the expected response. Returns just after the accepting edge with valid still high.
  task automatic send(input bit sel, input logic [4:0] tag, input logic [11:0] addr,
                      input logic wen, input logic [3:0] be, input bit chk_ready);
    logic [31:0] wd;
    bit          ok;
    wd = {tag, 3'b000, 12'h000, addr};
    if (!sel) begin
      a_req_valid = 1'b1; a_req_ini = tag; a_req_addr = addr;
      a_req_wen = wen; a_req_be = be; a_req_wdata = wd;
    end else begin
      b_req_valid = 1'b1; b_req_ini = tag; b_req_addr = addr;
      b_req_wen = wen; b_req_be = be; b_req_wdata = wd;
    end
    ok = 1'b0;
    @(negedge clk);
    if (chk_ready) check("ready_on_issue", sel ? b_req_ready : a_req_ready, 1);
    for (int i = 0; i < 40; i++) begin
      if (sel ? b_req_ready : a_req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("send_accepted", ok, 1);
    if (ok) begin
      check("mem_req", sel ? b_mem_req : a_mem_req, 1);
      check("mem_addr", sel ? b_mem_addr : a_mem_addr, addr);
      check("mem_wen", sel ? b_mem_wen : a_mem_wen, wen);
      check("mem_be", sel ? b_mem_be : a_mem_be, be);
      check("mem_wdata", sel ? b_mem_wdata : a_mem_wdata, wd);
      if (!sel) q_a.push_back({tag, wen ? 32'h0 : sram_val(addr)});
      else if (!wen) q_b.push_back({tag, sram_val(addr)});
    end
    @(posedge clk); #1;
  endtask

  task automatic set_bp(input int k);
    b_req_ini   = 5'(20 + k);
    b_req_addr  = 12'(12'h200 + k);
    b_req_wdata = 32'(k);
  endtask

  int k;

  initial begin
    a_req_valid = 0; a_req_ini = 0; a_req_addr = 0; a_req_wen = 0; a_req_be = 0; a_req_wdata = 0;
    b_req_valid = 0; b_req_ini = 0; b_req_addr = 0; b_req_wen = 0; b_req_be = 0; b_req_wdata = 0;
    a_resp_ready = 1; b_resp_ready = 1;
    #1 rst = 1'b1;
    a_req_valid = 1'b1;
    #2;
    check("rst_a_ready", a_req_ready, 0);
    check("rst_a_resp_valid", a_resp_valid, 0);
    check("rst_a_mem_req", a_mem_req, 0);
    check("rst_b_ready", b_req_ready, 0);
    check("rst_b_resp_valid", b_resp_valid, 0);
    a_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_a_ready", a_req_ready, 1);
    check("post_rst_b_ready", b_req_ready, 1);
    check("post_rst_a_cnt", dut_a.cnt, 0);
    @(posedge clk); #1;

    // Single read, MemLatency 2.
    send(0, 5'd5, 12'h010, 1'b0, 4'hF, 1);
    a_req_valid = 1'b0;
    @(negedge clk);
    check("t1_mem_req_pulse", a_mem_req, 0);
    check("t1_resp_not_early", a_resp_valid, 0);
    @(negedge clk);
    check("t1_resp_at_latency", a_resp_valid, 1);
    check("t1_resp_tag", a_resp_ini, 5);
    check("t1_resp_data", a_resp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_cnt_zero", dut_a.cnt, 0);
    @(posedge clk); #1;

    // Write with responses enabled returns zero data after MemLatency.
    send(0, 5'd7, 12'h020, 1'b1, 4'hF, 1);
    a_req_valid = 1'b0;
    @(negedge clk);
    check("wr_resp_not_early", a_resp_valid, 0);
    @(negedge clk);
    check("wr_resp_valid", a_resp_valid, 1);
    check("wr_resp_tag", a_resp_ini, 7);
    check("wr_resp_data", a_resp_rdata, 0);
    @(posedge clk); #1;

    // Back-to-back reads, full throughput.
    for (int i = 0; i < 16; i++) send(1, 5'(i * 3), 12'(12'h100 + i), 1'b0, 4'hF, 1);
    b_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_cnt_zero", dut_b.cnt, 0);
    @(posedge clk); #1;

    // Backpressure: exactly depth requests accepted, then resume one cycle after first pop.
    b_resp_ready = 1'b0;
    b_req_wen = 1'b0;
    b_req_be = 4'hF;
    k = 0;
    set_bp(k);
    b_req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (b_req_ready) begin
        q_b.push_back({5'(20 + k), sram_val(12'(12'h200 + k))});
        k++;
      end
      @(posedge clk); #1;
      set_bp(k);
    end
    check("bp_accept_count", k, 2);
    @(negedge clk);
    check("bp_ready_low", b_req_ready, 0);
    @(posedge clk); #1;
    b_resp_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_low_at_first_pop", b_req_ready, 0);
    check("bp_resp_valid", b_resp_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_accept_resumes", b_req_ready, 1);
    if (b_req_ready) begin
      q_b.push_back({5'(20 + k), sram_val(12'(12'h200 + k))});
      k++;
    end
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("bp_cnt_zero", dut_b.cnt, 0);
    @(posedge clk); #1;

    // Silent write.
    send(1, 5'd9, 12'h030, 1'b1, 4'b0011, 1);
    b_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wr_silent_no_resp", b_resp_valid, 0);
    end
    check("wr_silent_cnt", dut_b.cnt, 0);
    @(posedge clk); #1;

    // Simultaneous accept and pop at cnt = depth-1.
    send(1, 5'd11, 12'h040, 1'b0, 4'hF, 1);
    b_req_ini = 5'd12; b_req_addr = 12'h041; b_req_wdata = 32'h0;
    @(negedge clk);
    check("sim_ready", b_req_ready, 1);
    check("sim_resp_valid", b_resp_valid, 1);
    check("sim_cnt_before", dut_b.cnt, 1);
    if (b_req_ready) q_b.push_back({5'd12, sram_val(12'h041)});
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    @(negedge clk);
    check("sim_cnt_after", dut_b.cnt, 1);
    check("sim_ready_after", b_req_ready, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;

    // Reset with two requests in flight and one queued.
    a_resp_ready = 1'b0;
    send(0, 5'd1, 12'h050, 1'b0, 4'hF, 1);
    send(0, 5'd2, 12'h051, 1'b0, 4'hF, 1);
    send(0, 5'd3, 12'h052, 1'b0, 4'hF, 1);
    #1;
    check("rst_pre_resp_valid", a_resp_valid, 1);
    check("rst_pre_cnt", dut_a.cnt, 3);
    rst = 1'b1;
    #1;
    check("rst_async_resp_valid", a_resp_valid, 0);
    check("rst_async_ready", a_req_ready, 0);
    check("rst_async_mem_req", a_mem_req, 0);
    q_a.delete();
    q_b.delete();
    a_req_valid = 1'b0;
    a_resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_post_ready", a_req_ready, 1);
    check("rst_post_no_stale", a_resp_valid, 0);
    check("rst_post_cnt", dut_a.cnt, 0);

    for (int i = 0; i < 50 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    check("drain_a", q_a.size(), 0);
    check("drain_b", q_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
